// File: rtl/slicel_cfg_loader_if.sv
// Word-stream valid/ready handshake feeding the slice configuration loader.
interface slicel_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/slicel_cfg_loader.sv
// Slice configuration loader: assembles a word stream into a shadow frame, commits it, pulses cen.
// Optional SLICEL_CFG_CHECKSUM_EN: a trailing XOR checksum word gates the commit.
module slicel_cfg_loader #(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 8,
  parameter int CFG_SIZE  = 2*(2**S_XX_BASE)+1,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int FRAME_W   = CFG_SIZE*NUM_LUTS+MUX_LVLS+1+2*NUM_LUTS,
  parameter int NUM_WORDS = (FRAME_W+WORD_W-1)/WORD_W
) (
  input  logic                           cclk,
  input  logic                           rst,
  input  logic                           start,
  slicel_cfg_loader_if.slave             bus,
  output logic [CFG_SIZE*NUM_LUTS-1:0]   luts_config_in,
  output logic [MUX_LVLS-1:0]            inter_lut_mux_config,
  output logic                           config_use_cc,
  output logic [2*NUM_LUTS-1:0]          regs_config_in,
  output logic                           cen,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int SHADOW_W = NUM_WORDS*WORD_W;
  localparam int CNT_W    = $clog2(NUM_WORDS+1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_WORDS-1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef SLICEL_CFG_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
  localparam logic [CNT_W-1:0] CHK_IDX = CNT_W'(NUM_WORDS);

  // XOR of every shadow slot, padding bits of the last slot included.
  function automatic logic [WORD_W-1:0] word_xor(input logic [SHADOW_W-1:0] s);
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      acc = acc ^ s[i*WORD_W +: WORD_W];
    end
    return acc;
  endfunction

  logic [WORD_W-1:0] chk_q, chk_d;
  logic              err_q;
`endif

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0]  cfg_q, cfg_d;
  logic                cen_q, busy_q, in_ready_q, done_q;
  logic                accept_s;

  assign accept_s = bus.in_valid & in_ready_q;

  // Next-state, shadow-slot and commit logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
`ifdef SLICEL_CFG_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
`ifdef SLICEL_CFG_CHECKSUM_EN
          if (cnt_q == CHK_IDX) begin
            chk_d   = bus.in_data;
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            shadow_d[cnt_q*WORD_W +: WORD_W] = bus.in_data;
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          shadow_d[cnt_q*WORD_W +: WORD_W] = bus.in_data;
          if (cnt_q == LAST_DATA) begin
            // Last word goes straight to the outputs together with the lower slots.
            cfg_d   = shadow_d[FRAME_W-1:0];
            cnt_d   = '0;
            state_d = S_COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef SLICEL_CFG_CHECKSUM_EN
      S_CHECK: begin
        if (word_xor(shadow_q) == chk_q) begin
          cfg_d   = shadow_q[FRAME_W-1:0];
          state_d = S_COMMIT;
        end else begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_ERR;
        end
      end
`endif
      S_COMMIT: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and frame storage.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
`ifdef SLICEL_CFG_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
`ifdef SLICEL_CFG_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  // Status strobes are decoded from the next state so they line up with the state register.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      cen_q      <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SLICEL_CFG_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      cen_q      <= (state_d == S_COMMIT);
`ifdef SLICEL_CFG_CHECKSUM_EN
      busy_q     <= (state_d == S_LOAD) || (state_d == S_CHECK) || (state_d == S_COMMIT);
      err_q      <= (state_d == S_ERR);
`else
      busy_q     <= (state_d == S_LOAD) || (state_d == S_COMMIT);
`endif
      in_ready_q <= (state_d == S_LOAD);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign cen                   = cen_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
`ifdef SLICEL_CFG_CHECKSUM_EN
  assign err                   = err_q;
`else
  assign err                   = 1'b0;
`endif
  assign luts_config_in        = cfg_q[CFG_SIZE*NUM_LUTS-1:0];
  assign inter_lut_mux_config  = cfg_q[CFG_SIZE*NUM_LUTS +: MUX_LVLS];
  assign config_use_cc         = cfg_q[CFG_SIZE*NUM_LUTS+MUX_LVLS];
  assign regs_config_in        = cfg_q[FRAME_W-1 -: 2*NUM_LUTS];

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Directed-vector bench for slicel_cfg_loader at default parameters (143-bit frame, 18 words).
module tb_slicel_cfg_loader;
  localparam int NW = 18;
  localparam int FW = 143;
`ifdef SLICEL_CFG_CHECKSUM_EN
  localparam int NTOT = NW + 1;
  localparam int LAT0 = NW + 2;
`else
  localparam int NTOT = NW;
  localparam int LAT0 = NW;
`endif

  logic cclk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 cclk = ~cclk;

  slicel_cfg_loader_if #(.WORD_W(8)) bus ();

  logic [131:0] luts;
  logic [1:0]   mux;
  logic         cc;
  logic [7:0]   regs;
  logic         cen, busy, done, err;
  logic [FW-1:0] dut_cfg;
  assign dut_cfg = {regs, cc, mux, luts};

  slicel_cfg_loader dut (
    .cclk(cclk), .rst(rst), .start(start), .bus(bus),
    .luts_config_in(luts), .inter_lut_mux_config(mux), .config_use_cc(cc),
    .regs_config_in(regs), .cen(cen), .busy(busy), .done(done), .err(err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cen_total = 0;
  logic [7:0] wr [NW];
  logic [FW-1:0] basic_cfg;

  always @(posedge cclk) if (cen === 1'b1) cen_total++;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  function automatic logic [FW-1:0] pack_frame();
    logic [NW*8-1:0] f;
    for (int i = 0; i < NW; i++) f[i*8 +: 8] = wr[i];
    return f[FW-1:0];
  endfunction

  // Starts a frame and streams wr[] (plus checksum in the feature build), optionally stalling.
  task automatic send_frame(input int stall_at, input int stall_len, input logic bad_chk,
                            input logic chk_hold, input logic [FW-1:0] hold_val,
                            output int lat, output int rdy, output int cens,
                            output int busy_low, output int hold_bad, output logic [FW-1:0] at_cen);
    int k, stall, ticks;
    logic acc;
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 0; i < NW; i++) chk = chk ^ wr[i];
    if (bad_chk) chk = chk ^ 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; stall = 0; ticks = 0; rdy = 0; cens = 0; busy_low = 0; hold_bad = 0; lat = -1;
    at_cen = '0;
    while (k < NTOT && ticks < 200) begin
      if (k == stall_at && stall < stall_len) begin
        bus.in_valid = 1'b0;
        stall++;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = (k < NW) ? wr[k] : chk;
      end
      if (bus.in_ready === 1'b1) rdy++;
      if (busy !== 1'b1) busy_low++;
      if (cen === 1'b1) cens++;
      if (chk_hold && cens == 0 && dut_cfg !== hold_val) hold_bad++;
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      tick();
      ticks++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (cen === 1'b1) begin
        if (lat < 0) begin
          lat = ticks;
          at_cen = dut_cfg;
        end
        cens++;
      end else if (chk_hold && lat < 0 && dut_cfg !== hold_val) begin
        hold_bad++;
      end
      if (bus.in_ready === 1'b1) rdy++;
      tick();
      ticks++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    tick(); tick();
    vec_cnt++;
    if (dut_cfg !== {FW{1'b0}}) begin err_cnt++; $display("FAIL reset_cfg: got %0h expected 0", dut_cfg); end
    vec_cnt++;
    if ({cen, bus.in_ready, busy} !== 3'b000) begin err_cnt++; $display("FAIL reset_ctl: got %b expected 000", {cen, bus.in_ready, busy}); end
    vec_cnt++;
    if ({done, err} !== 2'b00) begin err_cnt++; $display("FAIL reset_status: got %b expected 00", {done, err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, rdy, cens, bl, hb;
    logic [FW-1:0] ac;
    for (int i = 0; i < NW; i++) wr[i] = 8'(i + 1);
    send_frame(-1, 0, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (rdy !== NTOT) begin err_cnt++; $display("FAIL basic_ready_cycles: got %0d expected %0d", rdy, NTOT); end
    vec_cnt++;
    if (lat !== LAT0) begin err_cnt++; $display("FAIL basic_cen_latency: got %0d expected %0d", lat, LAT0); end
    vec_cnt++;
    if (cens !== 1) begin err_cnt++; $display("FAIL basic_cen_width: got %0d expected 1", cens); end
    vec_cnt++;
    if (luts[7:0] !== 8'h01) begin err_cnt++; $display("FAIL basic_lut_lsb: got %0h expected 01", luts[7:0]); end
    vec_cnt++;
    if (regs !== 8'h24) begin err_cnt++; $display("FAIL basic_regs: got %0h expected 24", regs); end
    vec_cnt++;
    if ({cc, mux} !== 3'b001) begin err_cnt++; $display("FAIL basic_cc_mux: got %b expected 001", {cc, mux}); end
    vec_cnt++;
    if (dut_cfg !== pack_frame()) begin err_cnt++; $display("FAIL basic_frame: got %0h expected %0h", dut_cfg, pack_frame()); end
    vec_cnt++;
    if ({done, busy} !== 2'b10) begin err_cnt++; $display("FAIL basic_done: got %b expected 10", {done, busy}); end
    basic_cfg = pack_frame();
  endtask

  task automatic test_stall();
    int lat, rdy, cens, bl, hb;
    logic [FW-1:0] ac;
    send_frame(7, 5, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (lat !== LAT0 + 5) begin err_cnt++; $display("FAIL stall_cen_latency: got %0d expected %0d", lat, LAT0 + 5); end
    vec_cnt++;
    if (bl !== 0) begin err_cnt++; $display("FAIL stall_busy: got %0d low cycles expected 0", bl); end
    vec_cnt++;
    if (dut_cfg !== basic_cfg) begin err_cnt++; $display("FAIL stall_frame: got %0h expected %0h", dut_cfg, basic_cfg); end
    vec_cnt++;
    if (cens !== 1) begin err_cnt++; $display("FAIL stall_cen_width: got %0d expected 1", cens); end
  endtask

  task automatic test_padding();
    int lat, rdy, cens, bl, hb;
    logic [FW-1:0] ac, cfg_ff;
    for (int i = 0; i < NW; i++) wr[i] = 8'(i + 1);
    wr[NW-1] = 8'hFF;
    send_frame(-1, 0, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    cfg_ff = dut_cfg;
    vec_cnt++;
    if (regs !== 8'hFE) begin err_cnt++; $display("FAIL pad_ff_regs: got %0h expected fe", regs); end
    wr[NW-1] = 8'h7F;
    send_frame(-1, 0, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (dut_cfg !== cfg_ff) begin err_cnt++; $display("FAIL pad_ignored: got %0h expected %0h", dut_cfg, cfg_ff); end
    vec_cnt++;
    if (regs !== 8'hFE) begin err_cnt++; $display("FAIL pad_7f_regs: got %0h expected fe", regs); end
  endtask

  task automatic test_reset_mid();
    int lat, rdy, cens, bl, hb, c0;
    logic [FW-1:0] ac;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      tick();
    end
    bus.in_valid = 1'b0;
    c0 = cen_total;
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (dut_cfg !== {FW{1'b0}}) begin err_cnt++; $display("FAIL midrst_cfg: got %0h expected 0", dut_cfg); end
    vec_cnt++;
    if ({cen, bus.in_ready, busy, done} !== 4'b0000) begin err_cnt++; $display("FAIL midrst_ctl: got %b expected 0000", {cen, bus.in_ready, busy, done}); end
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (cen_total !== c0) begin err_cnt++; $display("FAIL midrst_no_cen: got %0d expected %0d", cen_total, c0); end
    for (int i = 0; i < NW; i++) wr[i] = 8'(8'hA0 + i);
    send_frame(-1, 0, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (dut_cfg !== pack_frame()) begin err_cnt++; $display("FAIL midrst_fresh_frame: got %0h expected %0h", dut_cfg, pack_frame()); end
    vec_cnt++;
    if (lat !== LAT0) begin err_cnt++; $display("FAIL midrst_fresh_latency: got %0d expected %0d", lat, LAT0); end
  endtask

  task automatic test_back_to_back();
    int lat, rdy, cens, bl, hb, c0;
    logic [FW-1:0] ac, cfg_a;
    c0 = cen_total;
    for (int i = 0; i < NW; i++) wr[i] = 8'hAA;
    send_frame(-1, 0, 1'b0, 1'b0, '0, lat, rdy, cens, bl, hb, ac);
    cfg_a = pack_frame();
    vec_cnt++;
    if (dut_cfg !== cfg_a) begin err_cnt++; $display("FAIL b2b_frame_a: got %0h expected %0h", dut_cfg, cfg_a); end
    for (int i = 0; i < NW; i++) wr[i] = 8'h55;
    send_frame(-1, 0, 1'b0, 1'b1, cfg_a, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (hb !== 0) begin err_cnt++; $display("FAIL b2b_hold_a: got %0d early changes expected 0", hb); end
    vec_cnt++;
    if (ac !== pack_frame()) begin err_cnt++; $display("FAIL b2b_switch_b: got %0h expected %0h", ac, pack_frame()); end
    vec_cnt++;
    if (cen_total - c0 !== 2) begin err_cnt++; $display("FAIL b2b_cen_count: got %0d expected 2", cen_total - c0); end
  endtask

  task automatic test_checksum();
    int lat, rdy, cens, bl, hb;
    logic [FW-1:0] ac, prev;
    prev = dut_cfg;
`ifdef SLICEL_CFG_CHECKSUM_EN
    for (int i = 0; i < NW; i++) wr[i] = 8'(i * 3 + 7);
    send_frame(-1, 0, 1'b1, 1'b1, prev, lat, rdy, cens, bl, hb, ac);
    vec_cnt++;
    if (cens !== 0) begin err_cnt++; $display("FAIL chk_bad_no_cen: got %0d expected 0", cens); end
    vec_cnt++;
    if ({err, done} !== 2'b10) begin err_cnt++; $display("FAIL chk_bad_err: got %b expected 10", {err, done}); end
    vec_cnt++;
    if (dut_cfg !== prev) begin err_cnt++; $display("FAIL chk_bad_hold: got %0h expected %0h", dut_cfg, prev); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt++;
    if ({err, bus.in_ready} !== 2'b01) begin err_cnt++; $display("FAIL chk_restart: got %b expected 01", {err, bus.in_ready}); end
`else
    vec_cnt++;
    if (err !== 1'b0) begin err_cnt++; $display("FAIL err_tied: got %b expected 0", err); end
    vec_cnt++;
    if (dut_cfg !== prev) begin err_cnt++; $display("FAIL idle_hold: got %0h expected %0h", dut_cfg, prev); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_padding();
    test_reset_mid();
    test_back_to_back();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
